// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: a TXDATA/STATUS register pair with a one-cycle
// enable/ready handshake, feeding a byte FIFO drained by a serialiser FSM.
module uart_tx_mmio #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        mem_ready,
  output logic        uart_tx
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
  localparam int unsigned PtrW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW       = PtrW + 1;
  localparam int unsigned BaudW      = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;

  localparam logic [BaudW-1:0] BaudReload = BaudW'(ClksPerBit - 1);
  localparam logic [CntW-1:0]  DepthCnt   = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Bus side
  logic        mem_ready_q;
  logic [31:0] data_out_q;
  logic        accept, wr_acc, rd_acc;
  logic [1:0]  reg_sel;
  logic [31:0] rdata;
  logic [31:0] status;

  // FIFO
  logic [7:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            fifo_full, fifo_empty;
  logic            push_req, push, pop;
  logic [7:0]      fifo_head;
  logic [7:0]      count8;

  // Serialiser
  state_e          state_q;
  logic [BaudW-1:0] baud_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  logic            busy;

  logic unused_bits;
  assign unused_bits = ^{address[31:4], address[1:0], data_in[31:8]};

  assign reg_sel = address[3:2];
  assign accept  = (write_enable | read_enable) & ~mem_ready_q;
  assign wr_acc  = accept & write_enable;
  // A simultaneous write wins; the read side then leaves data_out alone.
  assign rd_acc  = accept & read_enable & ~write_enable;

  assign fifo_full  = (count_q == DepthCnt);
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = fifo_mem_q[rd_ptr_q];
  assign busy       = (state_q != StIdle);
  assign count8     = 8'(count_q);

  assign pop      = ~fifo_empty &
                    ((state_q == StIdle) | ((state_q == StStop) & (baud_q == '0)));
  assign push_req = wr_acc & (reg_sel == 2'd0);
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign push     = push_req & (~fifo_full | pop);

  assign status = {16'h0000, count8, 4'h0, overflow_q, busy, fifo_empty, fifo_full};
  assign rdata  = (reg_sel == 2'd1) ? status : 32'h0000_0000;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (wr_acc && (reg_sel == 2'd1)) begin
      overflow_d = 1'b0;
    end else if (push_req && !push) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready_q <= 1'b0;
      data_out_q  <= 32'h0000_0000;
    end else begin
      mem_ready_q <= accept;
      if (rd_acc) begin
        data_out_q <= rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  // Storage needs no reset: count and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= data_in[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q <= fifo_head;
            baud_q  <= BaudReload;
            tx_q    <= 1'b0;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (baud_q != '0) begin
            baud_q <= baud_q - BaudW'(1);
          end else begin
            baud_q    <= BaudReload;
            tx_q      <= shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= 3'd0;
            state_q   <= StData;
          end
        end
        StData: begin
          if (baud_q != '0) begin
            baud_q <= baud_q - BaudW'(1);
          end else begin
            baud_q <= BaudReload;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
        end
        StStop: begin
          if (baud_q != '0) begin
            baud_q <= baud_q - BaudW'(1);
          end else if (!fifo_empty) begin
            // Chain straight into the next start bit.
            shift_q <= fifo_head;
            baud_q  <= BaudReload;
            tx_q    <= 1'b0;
            state_q <= StStart;
          end else begin
            tx_q    <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign mem_ready = mem_ready_q;
  assign uart_tx   = tx_q;

endmodule
